// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit: shift-add multiply, restoring
// divide, one bit per cycle, with start/busy/done handshake and a destination tag.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_RSV   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_opd;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic              r_fast;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag_out;

    // Accept-side decode
    logic            w_is_div, w_is_mul, w_signed, w_sa, w_sb, w_bzero, w_ovf;
    logic            w_fast, w_neg_flag, w_accept;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_fast_res;

    assign w_is_div = (op >= OP_DIV) && (op <= 3'd6);
    assign w_is_mul = (op <= OP_MULHU);
    assign w_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_sa     = w_signed & a[XLEN-1];
    assign w_sb     = w_signed & b[XLEN-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;
    assign w_bzero  = (b == '0);
    assign w_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == '1);
    assign w_fast   = (op == OP_RSV) || (w_is_div && w_bzero) || w_ovf;

    // Quotient follows sign difference, remainder follows the dividend
    assign w_neg_flag = ((op == OP_MULH) || (op == OP_DIV)) ? (w_sa ^ w_sb) :
                        (op == OP_REM) ? w_sa : 1'b0;

    always_comb begin
        w_fast_res = '0;
        if (w_is_div && w_bzero)
            w_fast_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
        else if (w_ovf && (op == OP_DIV))
            w_fast_res = a;
    end

    assign w_accept = start && !flush &&
                      (((r_state == S_IDLE) && !r_fast) || (r_state == S_DONE));

    // Iteration datapath: r_acc holds {hi, lo} = product or {remainder, quotient}
    logic [XLEN:0]     w_madd, w_shift, w_trial;
    logic [2*XLEN-1:0] w_acc_nxt;

    assign w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial = w_shift - {1'b0, r_opd};

    always_comb begin
        if (r_op <= OP_MULHU)
            w_acc_nxt = {w_madd, r_acc[XLEN-1:1]};
        else if (w_trial[XLEN])
            w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_sign_res;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        case (r_op)
            OP_MUL:           w_sign_res = w_prod[XLEN-1:0];
            OP_MULH,
            OP_MULHU:         w_sign_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:  w_sign_res = w_quo;
            default:          w_sign_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_opd     <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_fast    <= 1'b0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_fast  <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_tag <= tag_in;
            r_neg <= w_neg_flag;
            if (w_fast) begin
                // Fast result parks in r_acc for one non-busy cycle before DONE
                r_fast  <= 1'b1;
                r_state <= S_IDLE;
                r_acc   <= {{XLEN{1'b0}}, w_fast_res};
            end else begin
                r_state <= S_CALC;
                r_cnt   <= CW'(XLEN);
                r_acc   <= {{XLEN{1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
                r_opd   <= w_is_mul ? w_abs_a : w_abs_b;
            end
        end else begin
            case (r_state)
                S_IDLE: if (r_fast) begin
                    r_fast    <= 1'b0;
                    r_state   <= S_DONE;
                    r_result  <= r_acc[XLEN-1:0];
                    r_tag_out <= r_tag;
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= S_SIGN;
                end
                S_SIGN: begin
                    r_result  <= w_sign_res;
                    r_tag_out <= r_tag;
                    r_state   <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_CALC) || (r_state == S_SIGN);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign tag_out = r_tag_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic, fast paths, flush, reset and handshake timing.
module tb_muldiv_unit;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset, start, flush;
    logic [2:0]       op;
    logic [XLEN-1:0]  a, b;
    logic [TAG_W-1:0] tag_in;
    logic             busy, done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .tag_in(tag_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    // Pulse start for one accept edge, then count edges until done (bounded).
    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] t, output int lat, output logic bsy);
        @(negedge clk);
        op = o; a = x; b = y; tag_in = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bsy = busy;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
            bsy = bsy | busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
        #3;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_ctrl: busy/done=%b exp 00", {busy, done}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
        checks++; if (tag_out !== '0) begin errors++; $display("FAIL reset_tag: got %h exp 0", tag_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd2};
        logic [63:0] va  [3] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] vb  [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] ve  [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        int lat; logic bsy;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], va[i], vb[i], 5'(i + 10), lat, bsy);
            checks++; if (lat !== 65) begin errors++; $display("FAIL mul_lat[%0d]: got %0d exp 65", i, lat); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h exp %h", i, result, ve[i]); end
            checks++; if (tag_out !== 5'(i + 10)) begin errors++; $display("FAIL mul_tag[%0d]: got %0d exp %0d", i, tag_out, i + 10); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done[%0d]: got %b exp 0", i, busy); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse[%0d]: got %b exp 0", i, done); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{3'd3, 3'd5, 3'd4, 3'd6, 3'd3, 3'd5};
        logic [63:0] va  [6] = '{-64'sd7, -64'sd7, 64'd100, 64'd100, 64'd7, 64'd7};
        logic [63:0] vb  [6] = '{64'd2, 64'd2, 64'd7, 64'd7, -64'sd2, -64'sd2};
        logic [63:0] ve  [6] = '{-64'sd3, -64'sd1, 64'd14, 64'd2, -64'sd3, 64'd1};
        int lat; logic bsy;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], va[i], vb[i], 5'(i + 1), lat, bsy);
            checks++; if (lat !== 65) begin errors++; $display("FAIL div_lat[%0d]: got %0d exp 65", i, lat); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL div_result[%0d]: got %h exp %h", i, result, ve[i]); end
            checks++; if (tag_out !== 5'(i + 1)) begin errors++; $display("FAIL div_tag[%0d]: got %0d exp %0d", i, tag_out, i + 1); end
        end
    endtask

    task automatic test_fast();
        logic [2:0]  ops [6] = '{3'd3, 3'd6, 3'd5, 3'd3, 3'd5, 3'd7};
        logic [63:0] va  [6] = '{64'd5, 64'd5, 64'd9, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd123};
        logic [63:0] vb  [6] = '{64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd45};
        logic [63:0] ve  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd9, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        int lat; logic bsy;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], va[i], vb[i], 5'(i + 20), lat, bsy);
            checks++; if (lat !== 1) begin errors++; $display("FAIL fast_lat[%0d]: got %0d exp 1", i, lat); end
            checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL fast_busy[%0d]: got %b exp 0", i, bsy); end
            checks++; if (result !== ve[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h exp %h", i, result, ve[i]); end
            checks++; if (tag_out !== 5'(i + 20)) begin errors++; $display("FAIL fast_tag[%0d]: got %0d exp %0d", i, tag_out, i + 20); end
        end
    endtask

    task automatic test_flush();
        int lat, seen; logic bsy;
        logic [63:0] prev_res; logic [4:0] prev_tag;
        issue(3'd4, 64'd50, 64'd5, 5'd2, lat, bsy);  // DIVU 50/5 = 10
        prev_res = 64'd10; prev_tag = 5'd2;
        @(negedge clk);
        op = 3'd3; a = 64'd1000; b = 64'd3; tag_in = 5'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy); end
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done pulses exp 0", seen); end
        checks++; if (result !== prev_res) begin errors++; $display("FAIL flush_result_held: got %h exp %h", result, prev_res); end
        checks++; if (tag_out !== prev_tag) begin errors++; $display("FAIL flush_tag_held: got %0d exp %0d", tag_out, prev_tag); end
        issue(3'd0, 64'd3, 64'd4, 5'd7, lat, bsy);
        checks++; if (lat !== 65) begin errors++; $display("FAIL flush_mul_lat: got %0d exp 65", lat); end
        checks++; if (result !== 64'd12) begin errors++; $display("FAIL flush_mul_result: got %h exp 12", result); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        op = 3'd0; a = 64'd6; b = 64'd6; tag_in = 5'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_ctrl: busy/done=%b exp 00", {busy, done}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result: got %h exp 0", result); end
        checks++; if (tag_out !== '0) begin errors++; $display("FAIL rstmid_tag: got %0d exp 0", tag_out); end
        @(negedge clk) reset = 1'b1;
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (done || busy) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_lost: got %0d active cycles exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op = 3'd4; a = 64'd100; b = 64'd7; tag_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin @(posedge clk); #1; if (done) begin lat = n; break; end end
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_lat1: got %0d exp 65", lat); end
        checks++; if (result !== 64'd14) begin errors++; $display("FAIL b2b_result1: got %h exp 14", result); end
        op = 3'd6; tag_in = 5'd4;  // start stays high through the DONE cycle
        @(posedge clk); #1 start = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_no_gap: busy/done=%b exp 10", {busy, done}); end
        lat = -1;
        for (int n = 1; n <= 200; n++) begin @(posedge clk); #1; if (done) begin lat = n; break; end end
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_lat2: got %0d exp 65 (from DONE edge)", lat); end
        checks++; if (result !== 64'd2) begin errors++; $display("FAIL b2b_result2: got %h exp 2", result); end
        checks++; if (tag_out !== 5'd4) begin errors++; $display("FAIL b2b_tag2: got %0d exp 4", tag_out); end
    endtask

    task automatic test_busy_ignore();
        int lat, seen;
        @(negedge clk);
        op = 3'd0; a = 64'd3; b = 64'd4; tag_in = 5'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 3'd3; a = 64'd100; b = 64'd7; tag_in = 5'd9; start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = -1;
        for (int n = 6; n <= 200; n++) begin @(posedge clk); #1; if (done) begin lat = n; break; end end
        checks++; if (lat !== 65) begin errors++; $display("FAIL ignore_lat: got %0d exp 65", lat); end
        checks++; if (result !== 64'd12) begin errors++; $display("FAIL ignore_result: got %h exp 12", result); end
        checks++; if (tag_out !== 5'd1) begin errors++; $display("FAIL ignore_tag: got %0d exp 1", tag_out); end
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ignore_no_second: got %0d done pulses exp 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
